// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the ARM-subset multicycle controller.
// Holds the FSM state encoding, ALU control codes, condition codes and opcodes.
// Also provides the ARM condition evaluation used by the condition logic.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] ALUCTL_ADD = 2'b00;
  localparam logic [1:0] ALUCTL_SUB = 2'b01;
  localparam logic [1:0] ALUCTL_AND = 2'b10;
  localparam logic [1:0] ALUCTL_ORR = 2'b11;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_RSC = 4'b0111;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags = {N, Z, C, V}; the 1111 encoding never executes.
  function automatic logic cond_ex(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Condition logic: NZ/CV flag registers and the per-instruction condition bit.
// Latency: cond_q valid the cycle after DECODE; flags update on the edge ending EXECR/EXECI.
// Backpressure: none; updates are qualified by the FSM strobes only.
// Ports: clk, reset (async active-low), cond (Instr[31:28]), alu_flags {N,Z,C,V},
//        flag_w {NZ,CV} write mask, cond_latch (DECODE), flag_upd (EXECR/EXECI), cond_q.
module mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       cond_latch,
  input  logic       flag_upd,
  output logic       cond_q
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nz_q   <= 2'b00;
      cv_q   <= 2'b00;
      cond_q <= 1'b0;
    end else begin
      // Evaluated against registered flags so a same-cycle ALU result never leaks in.
      if (cond_latch) cond_q <= cond_ex(cond, {nz_q, cv_q});
      if (flag_upd && flag_w[1] && cond_q) nz_q <= alu_flags[3:2];
      if (flag_upd && flag_w[0] && cond_q) cv_q <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multicycle control unit: Moore FSM sequencing a shared ALU/memory datapath.
// Latency: B 3, DP 4, STR 4, LDR 5 cycles; +1 per MemReady-low cycle in FETCH/MEMRD/MEMWR.
// Backpressure: MemReady low holds FETCH/MEMRD/MEMWR (MEM_WAIT_EN=1), writes stay gated meanwhile.
// Ports: clk, reset (async active-low), Instr[31:12], ALUFlags {N,Z,C,V}, MemReady in;
//        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RegSrc, ImmSrc, ALUSrcA, ALUSrcB,
//        ResultSrc, ALUControl, RSCSignal out.
module arm_multicycle_controller
  import arm_mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  input  logic         MemReady,
  output logic         PCWrite,
  output logic         IRWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ALUControl,
  output logic         RSCSignal
);

  state_t     state_q, state_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       rd_pc;
  logic       mem_go;
  logic       cond_q;
  logic [1:0] flag_w;
  logic       alu_active;
  logic       unused_rn;

  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign rd_pc     = (rd == 4'hF);
  assign unused_rn = ^Instr[19:16];
  assign mem_go    = MemReady | ~MEM_WAIT_EN;

  assign RegSrc = {(op == OP_MEM), (op == OP_B)};
  assign ImmSrc = op;

  mc_condlogic u_condlogic (
    .clk        (clk),
    .reset      (reset),
    .cond       (Instr[31:28]),
    .alu_flags  (ALUFlags),
    .flag_w     (flag_w),
    .cond_latch (state_q == S_DECODE),
    .flag_upd   (alu_active),
    .cond_q     (cond_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_go;
        PCWrite   = mem_go;
        if (mem_go) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        if (mem_go) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_q;
        if (mem_go) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_q & ~rd_pc;
        PCWrite   = cond_q & rd_pc;
        state_d   = S_FETCH;
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = cond_q & ~rd_pc;
        PCWrite  = cond_q & rd_pc;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Enables must drop the instant reset asserts, not at the next edge.
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign alu_active = (state_q == S_EXECR) || (state_q == S_EXECI);

  // ALU decode is only live in the execute states; everywhere else the ALU adds.
  always_comb begin
    ALUControl = ALUCTL_ADD;
    RSCSignal  = 1'b0;
    flag_w     = 2'b00;
    if (alu_active) begin
      case (funct[4:1])
        CMD_ADD: begin
          ALUControl = ALUCTL_ADD;
          flag_w     = {funct[0], funct[0]};
        end
        CMD_SUB: begin
          ALUControl = ALUCTL_SUB;
          flag_w     = {funct[0], funct[0]};
        end
        CMD_AND: begin
          ALUControl = ALUCTL_AND;
          flag_w     = {funct[0], 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALUCTL_ORR;
          flag_w     = {funct[0], 1'b0};
        end
        CMD_RSC: begin
          ALUControl = ALUCTL_SUB;
          RSCSignal  = 1'b1;
          flag_w     = {funct[0], funct[0]};
        end
        default: begin
          ALUControl = ALUCTL_ADD;
          flag_w     = 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller: walks instructions cycle by cycle
// and compares the packed control outputs against hand-derived per-state vectors.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_arm_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, RSCSignal;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;

  int total = 0;
  int bad   = 0;

  arm_multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .RSCSignal  (RSCSignal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,RSCSignal}
  function automatic logic [13:0] mk(input logic pc, input logic ir, input logic mw,
                                     input logic rw, input logic adr, input logic [1:0] asa,
                                     input logic [1:0] asb, input logic [1:0] rs,
                                     input logic [1:0] alu, input logic rsc);
    return {pc, ir, mw, rw, adr, asa, asb, rs, alu, rsc};
  endfunction

  function automatic logic [13:0] obs();
    return {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
            ResultSrc, ALUControl, RSCSignal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Called on a falling edge: drive, check, advance one full cycle.
  task automatic step(input string tag, input logic [19:0] ins, input logic [3:0] fl,
                      input logic rdy, input logic [13:0] exp);
    Instr    = ins;
    ALUFlags = fl;
    MemReady = rdy;
    #1;
    chk(tag, {18'd0, obs()}, {18'd0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [13:0] v_rst, v_fetch, v_dec, v_exec_add, v_exec_sub, v_exec_rsc, v_execi_orr;
  logic [13:0] v_wb_rw, v_wb_pc, v_br_t, v_br_n, v_madr, v_mrd, v_mwb, v_mwr1, v_mwr0;

  initial begin
    v_rst       = mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    v_fetch     = mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    v_dec       = mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    v_exec_add  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_exec_sub  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 0);
    v_exec_rsc  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    v_execi_orr = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b11, 0);
    v_wb_rw     = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_wb_pc     = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_br_t      = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    v_br_n      = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    v_madr      = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 0);
    v_mrd       = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_mwb       = mk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
    v_mwr1      = mk(0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    v_mwr0      = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);

    reset = 1'b0; Instr = 20'h0; ALUFlags = 4'h0; MemReady = 1'b1;
    @(negedge clk); #1;
    chk("reset_outputs", {18'd0, obs()}, {18'd0, v_rst});
    @(negedge clk); #1;
    chk("reset_hold", {18'd0, obs()}, {18'd0, v_rst});
    @(negedge clk);
    reset = 1'b1;

    // ADD R1,R2,R3 (E0821003)
    step("add_fetch",  20'hE0821, 4'h0, 1, v_fetch);
    step("add_decode", 20'hE0821, 4'h0, 1, v_dec);
    step("add_execr",  20'hE0821, 4'h0, 1, v_exec_add);
    step("add_aluwb",  20'hE0821, 4'h0, 1, v_wb_rw);

    // SUBS R0,R1,R1 -> ALU reports Z=1,C=1
    step("subs_fetch",  20'hE0510, 4'h0, 1, v_fetch);
    step("subs_decode", 20'hE0510, 4'h0, 1, v_dec);
    step("subs_execr",  20'hE0510, 4'b0110, 1, v_exec_sub);
    step("subs_aluwb",  20'hE0510, 4'h0, 1, v_wb_rw);

    // BEQ taken on the latched Z (live ALUFlags deliberately zero)
    step("beq_fetch",  20'h0A000, 4'h0, 1, v_fetch);
    step("beq_decode", 20'h0A000, 4'h0, 1, v_dec);
    chk("b_regsrc", {30'd0, RegSrc}, 32'd1);
    chk("b_immsrc", {30'd0, ImmSrc}, 32'd2);
    step("beq_branch", 20'h0A000, 4'h0, 1, v_br_t);
    // BNE not taken, still 3 cycles
    step("bne_fetch",  20'h1A000, 4'h0, 1, v_fetch);
    step("bne_decode", 20'h1A000, 4'h0, 1, v_dec);
    step("bne_branch", 20'h1A000, 4'h0, 1, v_br_n);

    // LDR R4,[R5,#4] with two wait cycles in MEMRD -> 7 cycles
    step("ldr_fetch",  20'hE5954, 4'h0, 1, v_fetch);
    chk("ldr_regsrc", {30'd0, RegSrc}, 32'd2);
    chk("ldr_immsrc", {30'd0, ImmSrc}, 32'd1);
    step("ldr_decode", 20'hE5954, 4'h0, 1, v_dec);
    step("ldr_memadr", 20'hE5954, 4'h0, 1, v_madr);
    step("ldr_memrd_w1", 20'hE5954, 4'h0, 0, v_mrd);
    step("ldr_memrd_w2", 20'hE5954, 4'h0, 0, v_mrd);
    step("ldr_memrd",  20'hE5954, 4'h0, 1, v_mrd);
    step("ldr_memwb",  20'hE5954, 4'h0, 1, v_mwb);

    // STRNE with Z=1: walks MEMWR with MemWrite suppressed (one wait cycle)
    step("strne_fetch_w", 20'h15854, 4'h0, 0, v_rst);
    step("strne_fetch",  20'h15854, 4'h0, 1, v_fetch);
    step("strne_decode", 20'h15854, 4'h0, 1, v_dec);
    step("strne_memadr", 20'h15854, 4'h0, 1, v_madr);
    step("strne_memwr_w", 20'h15854, 4'h0, 0, v_mwr0);
    step("strne_memwr",  20'h15854, 4'h0, 1, v_mwr0);

    // RSCS R6,R7,R8 -> ALU reports N=1,V=1 (C=0)
    step("rscs_fetch",  20'hE0F76, 4'h0, 1, v_fetch);
    step("rscs_decode", 20'hE0F76, 4'h0, 1, v_dec);
    step("rscs_execr",  20'hE0F76, 4'b1001, 1, v_exec_rsc);
    step("rscs_aluwb",  20'hE0F76, 4'h0, 1, v_wb_rw);
    // C/V took the RSC result: BVS taken, BCS not
    step("bvs_fetch",  20'h6A000, 4'h0, 1, v_fetch);
    step("bvs_decode", 20'h6A000, 4'h0, 1, v_dec);
    step("bvs_branch", 20'h6A000, 4'h0, 1, v_br_t);
    step("bcs_fetch",  20'h2A000, 4'h0, 1, v_fetch);
    step("bcs_decode", 20'h2A000, 4'h0, 1, v_dec);
    step("bcs_branch", 20'h2A000, 4'h0, 1, v_br_n);

    // ORR PC,R0,#imm: EXECI path, Rd=15 writes PC instead of register file
    step("orr_fetch",  20'hE380F, 4'h0, 1, v_fetch);
    step("orr_decode", 20'hE380F, 4'h0, 1, v_dec);
    step("orr_execi",  20'hE380F, 4'h0, 1, v_execi_orr);
    step("orr_aluwb",  20'hE380F, 4'h0, 1, v_wb_pc);

    // STR (AL) interrupted by reset while MemWrite is held high
    step("str_fetch",  20'hE5854, 4'h0, 1, v_fetch);
    step("str_decode", 20'hE5854, 4'h0, 1, v_dec);
    step("str_memadr", 20'hE5854, 4'h0, 1, v_madr);
    MemReady = 1'b0;
    #1;
    chk("str_memwr_hold", {18'd0, obs()}, {18'd0, v_mwr1});
    #1;
    reset = 1'b0;
    #1;
    chk("str_reset_drop", {18'd0, obs()}, {18'd0, v_rst});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    MemReady = 1'b1;
    // N was 1 before reset; cleared flags make BMI fail
    step("bmi_fetch",  20'h4A000, 4'h0, 1, v_fetch);
    step("bmi_decode", 20'h4A000, 4'h0, 1, v_dec);
    step("bmi_branch", 20'h4A000, 4'h0, 1, v_br_n);
    step("end_fetch",  20'hE0821, 4'h0, 1, v_fetch);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
